// File: rtl/gbe_pkg.sv
// gbe_pkg: shared types and header layout for the GbE transmit arbiter.
// Holds header magic, FSM state enum, header field offsets and builder.
package gbe_pkg;

  localparam logic [7:0] GBE_HDR_MAGIC = 8'hA5;

  localparam int HDR_MAGIC_LSB = 24;
  localparam int HDR_CHAN_LSB  = 16;
  localparam int HDR_SEQ_LSB   = 0;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PASS
  } gbeState_t;

  function automatic logic [31:0] mkHeader(
    input logic [3:0]  chan,
    input logic [15:0] seq
  );
    logic [31:0] h;
    h = '0;
    h[HDR_MAGIC_LSB +: 8] = GBE_HDR_MAGIC;
    h[HDR_CHAN_LSB +: 4]  = chan;
    h[HDR_SEQ_LSB +: 16]  = seq;
    return h;
  endfunction

endpackage

// File: rtl/gbe_rr_arbiter.sv
// gbe_rr_arbiter: combinational round-robin pick starting after lastGrant.
// Ports: req, lastGrant, en in; grantOh, grantIdx, grantValid out.
module gbe_rr_arbiter
  import gbe_pkg::*;
#(
  parameter int NUM_CH = 4,
  localparam int IDX_W = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  lastGrant,
  input  logic              en,
  output logic [NUM_CH-1:0] grantOh,
  output logic [IDX_W-1:0]  grantIdx,
  output logic              grantValid
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    grantOh    = '0;
    grantIdx   = '0;
    grantValid = 1'b0;
    cand       = '0;
    if (en) begin
      for (int i = 1; i <= NUM_CH; i++) begin
        cand = IDX_W'((int'(lastGrant) + i) % NUM_CH);
        if (!grantValid && req[cand]) begin
          grantValid    = 1'b1;
          grantIdx      = cand;
          grantOh[cand] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/gbe_tx_stream_arbiter.sv
// gbe_tx_stream_arbiter: packet round-robin merge of NUM_CH streams, with
// packets split at MAX_WORDS beats. Optional header beat: GBE_ARB_HDR_EN.
// Ports: clk, reset_n; s_data/s_valid/s_last in, s_ready out per channel;
// m_data/m_valid/m_last/m_chan out, m_ready in; split_pulse out.
module gbe_tx_stream_arbiter
  import gbe_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int DATA_W    = 32,
  parameter int MAX_WORDS = 366
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_CH*DATA_W-1:0]   s_data,
  input  logic [NUM_CH-1:0]          s_valid,
  input  logic [NUM_CH-1:0]          s_last,
  output logic [NUM_CH-1:0]          s_ready,
  output logic [DATA_W-1:0]          m_data,
  output logic                       m_valid,
  output logic                       m_last,
  input  logic                       m_ready,
  output logic [$clog2(NUM_CH)-1:0]  m_chan,
  output logic                       split_pulse
);

  localparam int IDX_W = $clog2(NUM_CH);
  localparam int WC_W  = $clog2(MAX_WORDS + 1);

  gbeState_t state;
  gbeState_t stateNext;

  logic [IDX_W-1:0]  grantQ;
  logic [NUM_CH-1:0] grantOhQ;
  logic [IDX_W-1:0]  lastGrant;
  logic [WC_W-1:0]   wcnt;

  logic [NUM_CH-1:0] arbOh;
  logic [IDX_W-1:0]  arbIdx;
  logic              arbValid;

  logic              canLoad;
  logic              beatValid;
  logic              beatLast;
  logic [DATA_W-1:0] beatData;
  logic              atLimit;
  logic              accept;
  logic              endPkt;
  logic              hdrLoad;
  logic [DATA_W-1:0] hdrWord;

  gbe_rr_arbiter #(
    .NUM_CH(NUM_CH)
  ) uArb (
    .req       (s_valid),
    .lastGrant (lastGrant),
    .en        (state == IDLE),
    .grantOh   (arbOh),
    .grantIdx  (arbIdx),
    .grantValid(arbValid)
  );

  always_comb begin
    beatData = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (grantQ == IDX_W'(c)) begin
        beatData = s_data[c*DATA_W +: DATA_W];
      end
    end
  end

  assign canLoad   = !m_valid || m_ready;
  assign beatValid = s_valid[grantQ];
  assign beatLast  = s_last[grantQ];
  assign atLimit   = wcnt == WC_W'(MAX_WORDS - 1);
  assign accept    = (state == PASS) && canLoad && beatValid;
  assign endPkt    = accept && (beatLast || atLimit);

  // A natural s_last on the limit beat is not a split.
  assign split_pulse = endPkt && !beatLast;

  assign s_ready = (state == PASS && canLoad) ? grantOhQ : '0;

`ifdef GBE_ARB_HDR_EN
  logic [15:0] seq [NUM_CH];

  assign hdrLoad = (state == HDR) && canLoad;
  assign hdrWord = DATA_W'(mkHeader(4'(grantQ), seq[grantQ]));

  // Split segments count as packets too.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        seq[c] <= '0;
      end
    end else if (endPkt) begin
      seq[grantQ] <= seq[grantQ] + 16'd1;
    end
  end
`else
  assign hdrLoad = 1'b0;
  assign hdrWord = '0;
`endif

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: begin
        if (arbValid) begin
`ifdef GBE_ARB_HDR_EN
          stateNext = HDR;
`else
          stateNext = PASS;
`endif
        end
      end
      HDR: begin
        if (canLoad) stateNext = PASS;
      end
      PASS: begin
        if (endPkt) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      grantQ    <= '0;
      grantOhQ  <= '0;
      lastGrant <= IDX_W'(NUM_CH - 1);
      wcnt      <= '0;
      m_data    <= '0;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
      m_chan    <= '0;
    end else begin
      state <= stateNext;
      if (state == IDLE && arbValid) begin
        grantQ   <= arbIdx;
        grantOhQ <= arbOh;
      end
      if (endPkt) begin
        lastGrant <= grantQ;
        wcnt      <= '0;
      end else if (accept) begin
        wcnt <= wcnt + 1'b1;
      end
      if (hdrLoad) begin
        m_data  <= hdrWord;
        m_valid <= 1'b1;
        m_last  <= 1'b0;
        m_chan  <= grantQ;
      end else if (accept) begin
        m_data  <= beatData;
        m_valid <= 1'b1;
        m_last  <= beatLast || atLimit;
        m_chan  <= grantQ;
      end else if (m_ready) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gbe_tx_stream_arbiter.sv
// tb_gbe_tx_stream_arbiter: table-driven and scoreboard bench for the
// transmit arbiter with MAX_WORDS = 4; follows GBE_ARB_HDR_EN if defined.
module tb_gbe_tx_stream_arbiter;

  localparam int NCH  = 4;
  localparam int MAXW = 4;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic        first;
  } src_t;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic [1:0]  chan;
  } exp_t;

  typedef struct {
    int          chan;
    int          len;
    logic [31:0] base;
    bit          rnd;
    bit          gap;
    int          splits;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [127:0] s_data;
  logic [3:0]   s_valid;
  logic [3:0]   s_last;
  logic [3:0]   s_ready;
  logic [31:0]  m_data;
  logic         m_valid;
  logic         m_last;
  logic         m_ready;
  logic [1:0]   m_chan;
  logic         split_pulse;

  src_t        srcQ [NCH][$];
  exp_t        expQ [$];
  int          hsCycQ [$];
  logic [15:0] seqM [NCH];
  logic [3:0]  hs;
  bit          rnd;
  bit          gap;
  int          cyc;
  int          outCnt;
  int          checks;
  int          errors;
  int          splitCnt;
  logic        prevStall;
  logic [34:0] prevOut;
  vec_t        vecs [8];

  always #5 clk = ~clk;

  gbe_tx_stream_arbiter #(
    .NUM_CH   (NCH),
    .DATA_W   (32),
    .MAX_WORDS(MAXW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_last     (m_last),
    .m_ready    (m_ready),
    .m_chan     (m_chan),
    .split_pulse(split_pulse)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] hdrOf(input int c, input logic [15:0] s);
    return {8'hA5, 4'h0, 4'(c), s};
  endfunction

  task automatic pushPkt(input int c, input int len,
                         input logic [31:0] base);
    int done;
    int seg;
    done = 0;
    for (int i = 0; i < len; i++) begin
      srcQ[c].push_back('{data: base + 32'(i), last: (i == len - 1),
                          first: (i == 0)});
    end
    while (done < len) begin
      seg = (len - done > MAXW) ? MAXW : len - done;
`ifdef GBE_ARB_HDR_EN
      expQ.push_back('{data: hdrOf(c, seqM[c]), last: 1'b0, chan: 2'(c)});
`endif
      for (int k = 0; k < seg; k++) begin
        expQ.push_back('{data: base + 32'(done + k), last: (k == seg - 1),
                         chan: 2'(c)});
      end
      seqM[c] = seqM[c] + 16'd1;
      done += seg;
    end
  endtask

  task automatic clearAll();
    for (int c = 0; c < NCH; c++) begin
      srcQ[c].delete();
      seqM[c] = '0;
    end
    expQ.delete();
    hs        = '0;
    prevStall = 1'b0;
    splitCnt  = 0;
    outCnt    = 0;
    rnd       = 1'b0;
    gap       = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clk);
    #2 reset_n = 1'b0;
    clearAll();
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
  endtask

  task automatic waitDrain(input string name, input int limit);
    int n;
    bit busy;
    n = 0;
    do begin
      @(negedge clk);
      #2;
      busy = expQ.size() != 0;
      for (int c = 0; c < NCH; c++) begin
        if (srcQ[c].size() != 0) busy = 1'b1;
      end
      n++;
    end while (busy && n < limit);
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL %s: timeout with %0d beats outstanding, required 0",
               name, expQ.size());
    end
    repeat (2) @(negedge clk);
  endtask

  // Source drivers, handshake bookkeeping and output monitor.
  initial begin : engine
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset_n) begin
        for (int c = 0; c < NCH; c++) begin
          if (hs[c] && srcQ[c].size() > 0) void'(srcQ[c].pop_front());
        end
      end
      hs = '0;
      m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      for (int c = 0; c < NCH; c++) begin
        if (srcQ[c].size() > 0 &&
            !(gap && !srcQ[c][0].first && $urandom_range(0, 2) == 0)) begin
          s_valid[c]            = 1'b1;
          s_data[c*32 +: 32]    = srcQ[c][0].data;
          s_last[c]             = srcQ[c][0].last;
        end else begin
          s_valid[c]            = 1'b0;
          s_data[c*32 +: 32]    = '0;
          s_last[c]             = 1'b0;
        end
      end
      #1;
      if (reset_n) begin
        hs = s_valid & s_ready;
        chk("s_ready onehot", 64'($onehot0(s_ready)), 64'd1);
        if (m_valid && !m_ready) chk("s_ready stalled", 64'(s_ready), 64'd0);
        if (prevStall) begin
          chk("stall hold", {m_valid, m_last, m_chan, m_data},
              {1'b1, prevOut});
        end
        prevStall = m_valid && !m_ready;
        prevOut   = {m_last, m_chan, m_data};
        if (split_pulse) splitCnt++;
        if (m_valid && m_ready) begin
          outCnt++;
          hsCycQ.push_back(cyc);
          if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL beat: got unexpected data %h chan %0d", m_data,
                     m_chan);
          end else begin
            e = expQ.pop_front();
            chk("beat", {m_data, m_last, m_chan}, {e.data, e.last, e.chan});
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    int p;
    int bad;
    checks  = 0;
    errors  = 0;
    cyc     = 0;
    reset_n = 1'b0;
    s_valid = '0;
    s_last  = '0;
    s_data  = '0;
    m_ready = 1'b0;
    clearAll();

    vecs[0] = '{0, 4, 32'h0000_0000, 1'b0, 1'b0, 0};
    vecs[1] = '{0, 2, 32'h0000_0100, 1'b0, 1'b0, 0};
    vecs[2] = '{2, 10, 32'h0000_0200, 1'b0, 1'b0, 2};
    vecs[3] = '{3, 20, 32'h0000_1000, 1'b1, 1'b0, 4};
    vecs[4] = '{1, 5, 32'h0000_0300, 1'b0, 1'b0, 1};
    vecs[5] = '{2, 3, 32'h0000_0400, 1'b0, 1'b1, 0};
    vecs[6] = '{0, 1, 32'h0000_0500, 1'b1, 1'b0, 0};
    vecs[7] = '{3, 8, 32'h0000_2000, 1'b1, 1'b1, 1};

    #13;
    chk("rst m_valid", 64'(m_valid), 64'd0);
    chk("rst m_last", 64'(m_last), 64'd0);
    chk("rst m_data", 64'(m_data), 64'd0);
    chk("rst m_chan", 64'(m_chan), 64'd0);
    chk("rst s_ready", 64'(s_ready), 64'd0);
    chk("rst split_pulse", 64'(split_pulse), 64'd0);
    @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    #2;
    chk("idle s_ready", 64'(s_ready), 64'd0);
    chk("idle m_valid", 64'(m_valid), 64'd0);

    for (int i = 0; i < 8; i++) begin
      rnd      = vecs[i].rnd;
      gap      = vecs[i].gap;
      splitCnt = 0;
      pushPkt(vecs[i].chan, vecs[i].len, vecs[i].base);
      waitDrain($sformatf("vec%0d drain", i), 500);
      chk($sformatf("vec%0d splits", i), 64'(splitCnt), 64'(vecs[i].splits));
      rnd = 1'b0;
      gap = 1'b0;
    end

    // Round robin from reset: 1,2,3 then 1 again.
    doReset();
    for (int r = 0; r < 2; r++) begin
      for (int c = 1; c < NCH; c++) begin
        pushPkt(c, 2, 32'h0000_0B00 + 32'(16 * r + 4 * c));
      end
    end
    waitDrain("round robin", 200);

    // Stalled source mid-packet holds the grant; ch1 waits.
    doReset();
    gap = 1'b1;
    pushPkt(0, 3, 32'h0000_0700);
    pushPkt(1, 2, 32'h0000_0800);
    waitDrain("no preempt", 200);
    gap = 1'b0;

    // Back-to-back packets: one idle cycle, then full rate.
    doReset();
    hsCycQ.delete();
    pushPkt(0, 3, 32'h0000_0C00);
    pushPkt(1, 3, 32'h0000_0D00);
    waitDrain("gap drain", 200);
`ifdef GBE_ARB_HDR_EN
    p = 4;
`else
    p = 3;
`endif
    chk("gap beats", 64'(hsCycQ.size()), 64'(2 * p));
    if (hsCycQ.size() == 2 * p) begin
      chk("inter-packet gap", 64'(hsCycQ[p] - hsCycQ[p-1]), 64'd2);
      bad = 0;
      for (int k = 1; k < 2 * p; k++) begin
        if (k != p && hsCycQ[k] - hsCycQ[k-1] != 1) bad++;
      end
      chk("throughput", 64'(bad), 64'd0);
    end

    // Asynchronous reset in the middle of a packet.
    doReset();
    pushPkt(1, 10, 32'h0000_0600);
    n = 0;
    while (outCnt < 3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("mid-packet progress", 64'(outCnt >= 3), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("async m_valid", 64'(m_valid), 64'd0);
    chk("async m_last", 64'(m_last), 64'd0);
    chk("async m_data", 64'(m_data), 64'd0);
    chk("async m_chan", 64'(m_chan), 64'd0);
    chk("async s_ready", 64'(s_ready), 64'd0);
    chk("async split_pulse", 64'(split_pulse), 64'd0);
    clearAll();
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    pushPkt(0, 2, 32'h0000_0A00);
    pushPkt(2, 2, 32'h0000_0900);
    waitDrain("post-reset priority", 200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gbe_tx_stream_arbiter.md
# gbe_tx_stream_arbiter

Packet-level round-robin arbiter that merges `NUM_CH` independent AXI-stream sources into the single 32-bit transmit stream feeding the UDP packet builder and MAC. It replaces the single-source `tx_streaming_*` path in the GbE top level. Each output packet carries its source channel ID. Any source packet longer than `MAX_WORDS` beats is split so that no single transfer exceeds the Ethernet payload budget.

## Interface
Parameters:
- `NUM_CH`, 4: number of input channels, 2..16.
- `DATA_W`, 32: beat width in bits. Fixed at 32 to match the MAC user interface.
- `MAX_WORDS`, 366: maximum number of output payload beats per packet, header beat excluded. Must be 2 or more.

Ports:
- `clk`, input, 1: single clock for all logic.
- `reset_n`, input, 1: reset, asynchronous and active-low.
- `s_data`, input, `NUM_CH*DATA_W`: channel c occupies bits `[c*DATA_W +: DATA_W]`.
- `s_valid`, input, `NUM_CH`: per-channel valid.
- `s_last`, input, `NUM_CH`: per-channel end of packet.
- `s_ready`, output, `NUM_CH`: per-channel ready. At most one bit is high at any time.
- `m_data`, output, `DATA_W`: merged stream data.
- `m_valid`, output, 1: merged stream valid.
- `m_last`, output, 1: merged stream end of packet.
- `m_ready`, input, 1: downstream ready.
- `m_chan`, output, `$clog2(NUM_CH)`: channel ID of the current `m_data` beat.
- `split_pulse`, output, 1: one-cycle pulse when a packet is forcibly terminated at `MAX_WORDS`.

## Operation
The block is a state machine with three states: IDLE, HDR and PASS.

**IDLE**
- If any `s_valid` bit is set, grant the first valid channel found searching upward from `last_grant+1`, wrapping modulo `NUM_CH`.
- Next state is HDR when `GBE_ARB_HDR_EN` is defined, otherwise PASS.
- `s_ready` is all zeros in IDLE.

**HDR**
- Load the output register with the header word `{8'hA5, 4'h0, chan[3:0], seq[chan][15:0]}` with `m_last` = 0.
- Move to PASS once the header beat is loaded.

**PASS**
- `s_ready[grant] = !m_valid || m_ready`. All other `s_ready` bits are 0.
- Each accepted beat is loaded into the output register and increments `wcnt`.
- `m_last` = `s_last[grant] || (wcnt == MAX_WORDS-1)`.
- On acceptance of a beat with `m_last` = 1:
  - set `last_grant` = `grant`;
  - clear `wcnt`;
  - increment `seq[grant]`;
  - return to IDLE.
- If the last beat was forced (counter reached the limit without `s_last`), pulse `split_pulse` on that cycle. The rest of the source packet then competes again in later arbitration as a new packet.

**Counters and widths**
- `wcnt` is `$clog2(MAX_WORDS+1)` bits wide.
- `seq` is a 16-bit counter per channel that wraps from 0xFFFF to 0x0000. Every output packet counts, including split segments.

**Boundary conditions**
- A source deasserting `s_valid` mid-packet: the grant is held and the block waits. The grant is never abandoned before `m_last`.
- A channel presenting `s_last` on the same beat that the counter reaches the limit: treated as a natural end. No `split_pulse`.
- A new `s_valid` arriving while another channel is granted: it waits. No preemption.
- `reset_n` asserted mid-packet: the partial packet is dropped downstream with no `m_last`. The downstream packet builder must also be reset.

## Timing
- Output register: `m_data`, `m_valid`, `m_last` and `m_chan` are registered. Latency from an `s_*` handshake to `m_valid` is 1 cycle.
- Full throughput of 1 beat per cycle is sustained inside PASS while `m_ready` = 1.
- Inter-packet overhead is 1 IDLE cycle, plus 1 header cycle when `GBE_ARB_HDR_EN` is defined.
- `m_valid` and `m_data` hold stable while `m_valid && !m_ready`.
- Reset values:
  - `m_valid`, `m_last`, `m_data`, `m_chan`, `s_ready` and `split_pulse` are 0;
  - state is IDLE;
  - `last_grant` = `NUM_CH-1`, so channel 0 has first priority;
  - all `seq` counters are 0 and `wcnt` is 0.

## Configuration
- `GBE_ARB_HDR_EN` defined: every output packet starts with the header beat. `MAX_WORDS` limits payload beats only, so total packet length is at most `MAX_WORDS+1` beats.
- `GBE_ARB_HDR_EN` undefined: the HDR state and `seq` counters are not built. Output is payload only, and the channel is identified solely by `m_chan`.

## Structure
- Shared package `gbe_pkg` holds:
  - `GBE_HDR_MAGIC` = 8'hA5;
  - the state enum {IDLE, HDR, PASS};
  - the header field offsets.
- The round-robin grant logic is a natural sub-module: `gbe_rr_arbiter`, parametrised by `NUM_CH`. It takes request, `last_grant` and an enable, and returns a one-hot grant and the grant index.
- The top module holds the FSM, output register, word counter and sequence counters.

## Test plan
- **Single packet:** ch0 sends 4 beats (0x0..0x3) with `m_ready` held at 1 -> header 0xA5000000 followed by 0..3 with `m_last` on beat 3; `m_chan` = 0; ch0 `seq` becomes 1.
- **Round robin:** ch1, ch2 and ch3 each hold a 2-beat packet at the same cycle -> output order is 1, 2, 3, then 1 again on the next round.
- **Split:** with `MAX_WORDS` = 4, ch2 sends 10 beats -> three packets of 4, 4 and 2 payload beats; `split_pulse` fires twice; header `seq` values are 0, 1, 2.
- **Backpressure:** toggle `m_ready` pseudo-randomly during a 20-beat packet -> no beat lost or duplicated, `m_data` stable while stalled, and `s_ready[c]` tracks `!m_valid || m_ready`.
- **Async reset mid-packet:** assert `reset_n` = 0 on beat 3 -> all outputs are 0 within the same cycle; after release, channel 0 wins the first arbitration and `seq` restarts at 0.
- **Header off:** build without `GBE_ARB_HDR_EN` -> the first output beat equals source beat 0, and the inter-packet gap is exactly 1 cycle.
